// File: rtl/privmode_ctrl_if.sv
// Handshake bundle between the privileged decode/trap logic and privmode_ctrl.
// The master drives events and the slave (privmode_ctrl) returns mode, status and WFI state.
interface privmode_ctrl_if;
  logic        StallW;
  logic        TrapM;
  logic        DelegateM;
  logic        mretM;
  logic        sretM;
  logic        wfiM;
  logic        InterruptPendingM;
  logic        STATUS_TW;
  logic        StatusWriteM;
  logic [12:0] StatusWriteValM;
  logic [1:0]  PrivilegeModeW;
  logic        STATUS_MIE;
  logic        STATUS_MPIE;
  logic        STATUS_SIE;
  logic        STATUS_SPIE;
  logic        STATUS_SPP;
  logic [1:0]  STATUS_MPP;
  logic        WFIStallM;
  logic        WFITimeoutM;

  modport master (
    output StallW, TrapM, DelegateM, mretM, sretM, wfiM, InterruptPendingM,
           STATUS_TW, StatusWriteM, StatusWriteValM,
    input  PrivilegeModeW, STATUS_MIE, STATUS_MPIE, STATUS_SIE, STATUS_SPIE,
           STATUS_SPP, STATUS_MPP, WFIStallM, WFITimeoutM
  );

  modport slave (
    input  StallW, TrapM, DelegateM, mretM, sretM, wfiM, InterruptPendingM,
           STATUS_TW, StatusWriteM, StatusWriteValM,
    output PrivilegeModeW, STATUS_MIE, STATUS_MPIE, STATUS_SIE, STATUS_SPIE,
           STATUS_SPP, STATUS_MPP, WFIStallM, WFITimeoutM
  );
endinterface

// File: rtl/privmode_ctrl.sv
// Privilege mode and mstatus/sstatus interrupt-enable stack, updated on trap/mret/sret/CSR write,
// plus the WFI wait FSM that stalls until an interrupt is pending or the WFI timeout fires.
module privmode_ctrl #(
  parameter int S_SUPPORTED     = 1,
  parameter int U_SUPPORTED     = 1,
  parameter int WFI_TIMEOUT_BIT = 16
) (
  input  logic          clk,
  input  logic          reset,
  privmode_ctrl_if.slave bus
);
  localparam bit       L_S      = (S_SUPPORTED != 0);
  localparam bit       L_U      = (U_SUPPORTED != 0);
  localparam int       CW       = WFI_TIMEOUT_BIT + 1;
  localparam logic [1:0] MPP_RST = L_U ? 2'b00 : 2'b11;
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} wfi_state_t;

  logic [1:0]    r_mode, w_mode_next;
  logic          r_mie, w_mie_next, r_mpie, w_mpie_next;
  logic          r_sie, w_sie_next, r_spie, w_spie_next;
  logic          r_spp, w_spp_next;
  logic [1:0]    r_mpp, w_mpp_next;
  wfi_state_t    r_state, w_state_next;
  logic [CW-1:0] r_wfi_cnt;
  logic          w_delegate, w_mpp_legal, w_tmo_applicable;
  logic          w_wfi_stall, w_wfi_timeout;
  logic          w_unused_wval;

  // Write-data bits that do not map to any field held here.
  assign w_unused_wval = ^{bus.StatusWriteValM[10:9], bus.StatusWriteValM[6],
                           bus.StatusWriteValM[4], bus.StatusWriteValM[2],
                           bus.StatusWriteValM[0]};

  assign w_delegate = bus.DelegateM & L_S & (r_mode != 2'b11);

  always_comb begin
    w_mpp_legal = 1'b0;
    case (bus.StatusWriteValM[12:11])
      2'b11:   w_mpp_legal = 1'b1;
      2'b01:   w_mpp_legal = L_S;
      2'b00:   w_mpp_legal = L_U;
      default: w_mpp_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_mode_next = r_mode;
    w_mie_next  = r_mie;
    w_mpie_next = r_mpie;
    w_sie_next  = r_sie;
    w_spie_next = r_spie;
    w_spp_next  = r_spp;
    w_mpp_next  = r_mpp;
    if (!bus.StallW) begin
      if (bus.TrapM) begin
        if (w_delegate) begin
          w_spie_next = r_sie;
          w_sie_next  = 1'b0;
          w_spp_next  = r_mode[0];
          w_mode_next = 2'b01;
        end else begin
          w_mpie_next = r_mie;
          w_mie_next  = 1'b0;
          w_mpp_next  = r_mode;
          w_mode_next = 2'b11;
        end
      end else if (bus.mretM) begin
        w_mode_next = r_mpp;
        w_mie_next  = r_mpie;
        w_mpie_next = 1'b1;
        w_mpp_next  = MPP_RST;
      end else if (bus.sretM) begin
        w_mode_next = {1'b0, r_spp};
        w_sie_next  = r_spie;
        w_spie_next = 1'b1;
        w_spp_next  = 1'b0;
      end else if (bus.StatusWriteM) begin
        w_sie_next  = bus.StatusWriteValM[1];
        w_mie_next  = bus.StatusWriteValM[3];
        w_spie_next = bus.StatusWriteValM[5];
        w_mpie_next = bus.StatusWriteValM[7];
        w_spp_next  = bus.StatusWriteValM[8];
        if (w_mpp_legal) w_mpp_next = bus.StatusWriteValM[12:11];
      end
    end
    // Supervisor fields read as zero when S mode is absent.
    if (!L_S) begin
      w_sie_next  = 1'b0;
      w_spie_next = 1'b0;
      w_spp_next  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode <= 2'b11;
      r_mie  <= 1'b0;
      r_mpie <= 1'b0;
      r_sie  <= 1'b0;
      r_spie <= 1'b0;
      r_spp  <= 1'b0;
      r_mpp  <= MPP_RST;
    end else begin
      r_mode <= w_mode_next;
      r_mie  <= w_mie_next;
      r_mpie <= w_mpie_next;
      r_sie  <= w_sie_next;
      r_spie <= w_spie_next;
      r_spp  <= w_spp_next;
      r_mpp  <= w_mpp_next;
    end
  end

  // WFI FSM: state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset || r_state == ST_IDLE) r_wfi_cnt <= '0;
    else                             r_wfi_cnt <= r_wfi_cnt + CNT_ONE;
  end

  // WFI FSM: next state. Entry is only evaluated in IDLE, so a wfiM held high
  // by the stalled pipeline cannot re-enter the wait.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.wfiM & ~bus.StallW & ~bus.TrapM & ~bus.InterruptPendingM)
                 w_state_next = ST_WAIT;
      ST_WAIT: if (bus.InterruptPendingM | w_wfi_timeout | bus.TrapM)
                 w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_tmo_applicable = L_U & ((bus.STATUS_TW & (r_mode != 2'b11)) |
                                   (L_S & (r_mode == 2'b00)));

  // WFI FSM: outputs, combinational so the stall drops with the interrupt.
  always_comb begin
    w_wfi_stall   = 1'b0;
    w_wfi_timeout = 1'b0;
    if (r_state == ST_WAIT) begin
      w_wfi_stall   = ~bus.InterruptPendingM;
      w_wfi_timeout = r_wfi_cnt[WFI_TIMEOUT_BIT] & w_tmo_applicable & ~bus.InterruptPendingM;
    end
  end

  assign bus.PrivilegeModeW = r_mode;
  assign bus.STATUS_MIE     = r_mie;
  assign bus.STATUS_MPIE    = r_mpie;
  assign bus.STATUS_SIE     = r_sie;
  assign bus.STATUS_SPIE    = r_spie;
  assign bus.STATUS_SPP     = r_spp;
  assign bus.STATUS_MPP     = r_mpp;
  assign bus.WFIStallM      = w_wfi_stall;
  assign bus.WFITimeoutM    = w_wfi_timeout;
endmodule

// File: tb/tb_privmode_ctrl.sv
// Directed bench for privmode_ctrl: table of status-stack vectors plus WFI sequences.
module tb_privmode_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_total = 0;

  privmode_ctrl_if bus();

  privmode_ctrl #(.S_SUPPORTED(1), .U_SUPPORTED(1), .WFI_TIMEOUT_BIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, trap, deleg, mret, sret, swr;
    logic [12:0] wval;
    logic [8:0]  exp; // {mode, mie, mpie, sie, spie, spp, mpp}
    string       name;
  } vec_t;

  vec_t vecs[19];

  function automatic logic [8:0] status_now();
    return {bus.PrivilegeModeW, bus.STATUS_MIE, bus.STATUS_MPIE, bus.STATUS_SIE,
            bus.STATUS_SPIE, bus.STATUS_SPP, bus.STATUS_MPP};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic clear_inputs();
    bus.StallW = 0; bus.TrapM = 0; bus.DelegateM = 0; bus.mretM = 0; bus.sretM = 0;
    bus.wfiM = 0; bus.InterruptPendingM = 0; bus.STATUS_TW = 0;
    bus.StatusWriteM = 0; bus.StatusWriteValM = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic do_mret();
    bus.mretM = 1;
    @(negedge clk);
    bus.mretM = 0;
  endtask

  task automatic do_swr(input logic [12:0] v);
    bus.StatusWriteM = 1; bus.StatusWriteValM = v;
    @(negedge clk);
    bus.StatusWriteM = 0; bus.StatusWriteValM = '0;
  endtask

  // Raise wfiM at the current negedge, then observe n cycles; a timeout drops wfiM.
  task automatic wfi_run(input int n, output int st, output int to);
    st = 0; to = 0;
    bus.wfiM = 1;
    #1;
    if (bus.WFIStallM) st++;
    for (int c = 0; c < n; c++) begin
      @(negedge clk); #1;
      if (bus.WFITimeoutM) begin
        to++;
        bus.wfiM = 0;
      end else if (bus.WFIStallM) st++;
    end
  endtask

  task automatic end_by_irq(input string name);
    bus.InterruptPendingM = 1;
    #1;
    check({name, "_stall_drop"}, 32'(bus.WFIStallM), 32'd0);
    @(negedge clk);
    bus.InterruptPendingM = 0; bus.wfiM = 0;
    #1;
    check({name, "_idle"}, 32'({bus.WFIStallM, bus.WFITimeoutM}), 32'd0);
  endtask

  int st, to;

  initial begin
    vecs[0]  = '{0,0,0,0,0,1,13'h0008, 9'b11_1_0_0_0_0_00, "swr_mie"};
    vecs[1]  = '{0,1,0,0,0,0,13'h0000, 9'b11_0_1_0_0_0_11, "trap_m"};
    vecs[2]  = '{0,0,0,1,0,0,13'h0000, 9'b11_1_1_0_0_0_00, "mret_m"};
    vecs[3]  = '{0,0,0,0,0,1,13'h0008, 9'b11_1_0_0_0_0_00, "swr_mpp00"};
    vecs[4]  = '{0,0,0,1,0,0,13'h0000, 9'b00_0_1_0_0_0_00, "mret_to_u"};
    vecs[5]  = '{0,0,0,0,0,1,13'h0082, 9'b00_0_1_1_0_0_00, "swr_sie"};
    vecs[6]  = '{0,1,1,0,0,0,13'h0000, 9'b01_0_1_0_1_0_00, "deleg_trap_u"};
    vecs[7]  = '{0,0,0,0,1,0,13'h0000, 9'b00_0_1_1_1_0_00, "sret_to_u"};
    vecs[8]  = '{0,1,0,0,0,0,13'h0000, 9'b11_0_0_1_1_0_00, "trap_u"};
    vecs[9]  = '{0,1,1,0,0,0,13'h0000, 9'b11_0_0_1_1_0_11, "deleg_in_m"};
    vecs[10] = '{0,0,0,0,0,1,13'h1000, 9'b11_0_0_0_0_0_11, "swr_mpp10"};
    vecs[11] = '{0,0,0,0,0,1,13'h0908, 9'b11_1_0_0_0_1_01, "swr_mpp01"};
    vecs[12] = '{0,1,0,1,0,0,13'h0000, 9'b11_0_1_0_0_1_11, "trap_and_mret"};
    vecs[13] = '{1,0,0,1,0,0,13'h0000, 9'b11_0_1_0_0_1_11, "stall_mret"};
    vecs[14] = '{1,1,0,0,0,1,13'h1FFF, 9'b11_0_1_0_0_1_11, "stall_trap_swr"};
    vecs[15] = '{0,0,0,1,0,0,13'h0000, 9'b11_1_1_0_0_1_00, "mret_back"};
    vecs[16] = '{0,0,0,0,1,0,13'h0000, 9'b01_1_1_0_1_0_00, "sret_m"};
    vecs[17] = '{0,1,1,0,0,0,13'h0000, 9'b01_1_1_0_0_1_00, "deleg_trap_s"};
    vecs[18] = '{0,0,0,0,1,1,13'h1FFF, 9'b01_1_1_0_1_0_00, "sret_beats_swr"};

    reset = 1;
    clear_inputs();
    repeat (2) @(negedge clk);
    check("reset_status", 32'(status_now()), 32'(9'b11_0_0_0_0_0_00));
    check("reset_wfi", 32'({bus.WFIStallM, bus.WFITimeoutM}), 32'd0);
    reset = 0;

    for (int i = 0; i < 19; i++) begin
      bus.StallW = vecs[i].stall; bus.TrapM = vecs[i].trap; bus.DelegateM = vecs[i].deleg;
      bus.mretM = vecs[i].mret; bus.sretM = vecs[i].sret;
      bus.StatusWriteM = vecs[i].swr; bus.StatusWriteValM = vecs[i].wval;
      @(negedge clk);
      clear_inputs();
      $display("vec %0d %s status=%b", i, vecs[i].name, status_now());
      check(vecs[i].name, 32'(status_now()), 32'(vecs[i].exp));
    end

    // M mode, interrupt after 10 waiting cycles
    do_reset();
    wfi_run(10, st, to);
    $display("wfi_m_irq stall_cycles=%0d timeouts=%0d", st, to);
    check("wfi_m_irq_stall", 32'(st), 32'd10);
    check("wfi_m_irq_tmo", 32'(to), 32'd0);
    end_by_irq("wfi_m_irq");

    // U mode, timeout after 16 stalled cycles
    do_reset();
    do_mret();
    wfi_run(30, st, to);
    $display("wfi_u_tmo stall_cycles=%0d timeouts=%0d", st, to);
    check("wfi_u_tmo_stall", 32'(st), 32'd16);
    check("wfi_u_tmo_pulse", 32'(to), 32'd1);
    check("wfi_u_tmo_idle", 32'(bus.WFIStallM), 32'd0);

    // M mode with TW=1: no timeout, holds until interrupt
    do_reset();
    bus.STATUS_TW = 1;
    wfi_run(30, st, to);
    $display("wfi_m_tw stall_cycles=%0d timeouts=%0d", st, to);
    check("wfi_m_tw_stall", 32'(st), 32'd30);
    check("wfi_m_tw_tmo", 32'(to), 32'd0);
    end_by_irq("wfi_m_tw");

    // S mode with TW=0: timeout not applicable
    do_reset();
    do_swr(13'h0800);
    do_mret();
    check("s_mode_entry", 32'(bus.PrivilegeModeW), 32'd1);
    wfi_run(24, st, to);
    $display("wfi_s_notw stall_cycles=%0d timeouts=%0d", st, to);
    check("wfi_s_notw_stall", 32'(st), 32'd24);
    check("wfi_s_notw_tmo", 32'(to), 32'd0);
    end_by_irq("wfi_s_notw");

    // Interrupt already pending: retires as nop
    do_reset();
    bus.InterruptPendingM = 1;
    wfi_run(5, st, to);
    $display("wfi_pending stall_cycles=%0d", st);
    check("wfi_pending_stall", 32'(st), 32'd0);
    bus.InterruptPendingM = 0; bus.wfiM = 0;
    @(negedge clk); #1;
    check("wfi_pending_idle", 32'(bus.WFIStallM), 32'd0);

    // StallW blocks entry
    bus.wfiM = 1; bus.StallW = 1;
    @(negedge clk);
    bus.wfiM = 0; bus.StallW = 0;
    #1;
    $display("wfi_stallw stall=%0b", bus.WFIStallM);
    check("wfi_stallw_no_entry", 32'(bus.WFIStallM), 32'd0);

    // Trap exits the wait
    wfi_run(3, st, to);
    check("wfi_trap_wait", 32'(st), 32'd3);
    bus.TrapM = 1; bus.wfiM = 0;
    @(negedge clk);
    bus.TrapM = 0;
    #1;
    $display("wfi_trap_exit stall=%0b", bus.WFIStallM);
    check("wfi_trap_exit", 32'(bus.WFIStallM), 32'd0);

    // Reset in the middle of a U-mode wait
    do_reset();
    do_mret();
    wfi_run(3, st, to);
    check("wfi_rst_wait", 32'(st), 32'd3);
    reset = 1; bus.wfiM = 0;
    @(negedge clk); #1;
    $display("wfi_rst stall=%0b mode=%b", bus.WFIStallM, bus.PrivilegeModeW);
    check("wfi_rst_stall", 32'(bus.WFIStallM), 32'd0);
    check("wfi_rst_mode", 32'(bus.PrivilegeModeW), 32'd3);
    reset = 0;
    @(negedge clk); #1;
    check("wfi_rst_idle", 32'(bus.WFIStallM), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
